// File: rtl/aes_pkg.sv
// Shared AES-128 key schedule definitions: round count, Rcon and S-box tables,
// state encoding and the word helpers used by the one-round expansion step.
package aes_pkg;

    localparam int AES128_NR = 10;

    typedef logic [127:0] round_key_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } ks_state_e;

    // Rcon bytes live at indices 1..10; the padding entries keep every 4-bit index in range.
    localparam logic [0:15][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes128_key_schedule_ctrl_kexp.sv
// One AES-128 key-expansion round: derives round key r from round key r-1 and
// the round constant word. Purely combinational.
module keyExpansion128
    import aes_pkg::*;
(
    input  logic [127:0] key_in,
    input  logic [31:0]  rcon,
    output logic [127:0] key_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] w4, w5, w6, w7;
    logic [31:0] temp;

    always_comb begin
        w0   = key_in[127:96];
        w1   = key_in[95:64];
        w2   = key_in[63:32];
        w3   = key_in[31:0];
        temp = sub_word(rot_word(w3)) ^ rcon;
        w4   = w0 ^ temp;
        w5   = w4 ^ w1;
        w6   = w5 ^ w2;
        w7   = w6 ^ w3;
        key_out = {w4, w5, w6, w7};
    end

endmodule

// File: rtl/aes128_key_schedule_ctrl.sv
// AES-128 key schedule sequencer: expands one round key per clock into a local
// register file and serves a registered random-access read port.
//
// state  | meaning
// IDLE   | waiting for start; schedule (if keys_valid) is stable and readable
// EXPAND | writing rk[round] from rk[round-1], round = 1..NR
module aes128_key_schedule_ctrl
    import aes_pkg::*;
#(
    parameter int NR    = 10,
    parameter int RK_AW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [127:0]     key,
    output logic             busy,
    output logic             done,
    output logic             keys_valid,
    output logic             rk_wr_valid,
    output logic [3:0]       rk_wr_round,
    output logic [127:0]     rk_wr_data,
    input  logic [RK_AW-1:0] rd_addr,
    output logic [127:0]     rd_data
);

    if (NR != AES128_NR) begin : g_bad_nr
        $error("aes128_key_schedule_ctrl supports only NR = 10 (AES-128)");
    end

    localparam logic [3:0]       LAST_ROUND = 4'(NR);
    localparam logic [RK_AW-1:0] LAST_ADDR  = RK_AW'(NR);

    ks_state_e  state_q, state_d;
    logic [3:0] round_q, round_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       keys_valid_q, keys_valid_d;
    logic       rk_wr_valid_q, rk_wr_valid_d;
    logic [3:0] rk_wr_round_q, rk_wr_round_d;
    round_key_t rk_wr_data_q, rk_wr_data_d;
    round_key_t rd_data_q, rd_data_d;

    round_key_t rk_q [0:NR];
    logic       rk_we;
    logic [3:0] rk_widx;
    round_key_t rk_wdata;

    logic [3:0] prev_idx;
    round_key_t kexp_in;
    round_key_t kexp_out;
    logic [31:0] kexp_rcon;

    keyExpansion128 u_key_expansion (
        .key_in  (kexp_in),
        .rcon    (kexp_rcon),
        .key_out (kexp_out)
    );

    // Feed the expansion step from the previous stored round key.
    always_comb begin
        prev_idx  = (round_q == 4'd0) ? 4'd0 : round_q - 4'd1;
        kexp_in   = rk_q[prev_idx];
        kexp_rcon = {RCON[round_q], 24'h000000};
    end

    always_comb begin
        state_d       = state_q;
        round_d       = round_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        keys_valid_d  = keys_valid_q;
        rk_wr_round_d = rk_wr_round_q;
        rk_wr_data_d  = rk_wr_data_q;
        rk_we         = 1'b0;
        rk_widx       = round_q;
        rk_wdata      = kexp_out;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rk_we         = 1'b1;
                    rk_widx       = 4'd0;
                    rk_wdata      = key;
                    rk_wr_round_d = 4'd0;
                    rk_wr_data_d  = key;
                    round_d       = 4'd1;
                    keys_valid_d  = 1'b0;
                    busy_d        = 1'b1;
                    state_d       = EXPAND;
                end
            end
            EXPAND: begin
                rk_we         = 1'b1;
                rk_wr_round_d = round_q;
                rk_wr_data_d  = kexp_out;
                if (round_q == LAST_ROUND) begin
                    round_d      = 4'd0;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    keys_valid_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        rk_wr_valid_d = rk_we;
    end

    // Registered read, no write-through: same-edge writes are seen a cycle later.
    always_comb begin
        rd_data_d = (rd_addr > LAST_ADDR) ? '0 : rk_q[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            round_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            keys_valid_q  <= 1'b0;
            rk_wr_valid_q <= 1'b0;
            rk_wr_round_q <= '0;
            rk_wr_data_q  <= '0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            round_q       <= round_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            keys_valid_q  <= keys_valid_d;
            rk_wr_valid_q <= rk_wr_valid_d;
            rk_wr_round_q <= rk_wr_round_d;
            rk_wr_data_q  <= rk_wr_data_d;
            rd_data_q     <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rk_we && !rst) begin
            rk_q[rk_widx] <= rk_wdata;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign keys_valid  = keys_valid_q;
    assign rk_wr_valid = rk_wr_valid_q;
    assign rk_wr_round = rk_wr_round_q;
    assign rk_wr_data  = rk_wr_data_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_aes128_key_schedule_ctrl.sv
// Self-checking bench for aes128_key_schedule_ctrl: known-answer table plus random
// keys against a word-level FIPS-197 reference model, and multi-cycle corner cases.
module tb_aes128_key_schedule_ctrl;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic         rk_wr_valid;
    logic [3:0]   rk_wr_round;
    logic [127:0] rk_wr_data;
    logic [3:0]   rd_addr;
    logic [127:0] rd_data;

    aes128_key_schedule_ctrl #(.NR(10), .RK_AW(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .key         (key),
        .busy        (busy),
        .done        (done),
        .keys_valid  (keys_valid),
        .rk_wr_valid (rk_wr_valid),
        .rk_wr_round (rk_wr_round),
        .rk_wr_data  (rk_wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    int done_cnt;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] data;
    } wr_t;
    wr_t wr_q[$];

    typedef struct {
        logic [127:0] k;
        logic [127:0] rk1;
        logic [127:0] rk10;
    } vec_t;

    logic [7:0]   sbox_m [256];
    logic [127:0] exp_rk [11];

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            y = {1'b0, y[7:1]};
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v};
        return d[15-n -: 8];
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8), then affine map.
    task automatic init_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t = t ^ {rc, 24'h000000};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rk_wr_valid) wr_q.push_back('{rnd: rk_wr_round, data: rk_wr_data});
            if (done) done_cnt++;
        end
    end

    task automatic pulse_start(input logic [127:0] k);
        @(negedge clk);
        start = 1'b1;
        key   = k;
        @(posedge clk);
        #1;
        start = 1'b0;
        key   = {$urandom, $urandom, $urandom, $urandom};
        wr_q.delete();
    endtask

    // lat = edges after the sampling edge until done is seen; -1 if it never shows.
    task automatic wait_done(output int lat, output int bcy);
        lat = -1;
        bcy = 0;
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            if (busy) bcy++;
            if (done) begin
                lat = n - 1;
                break;
            end
            @(posedge clk);
        end
        #1;
    endtask

    task automatic do_expand(input string tag, input logic [127:0] k);
        int lat, bcy;
        pulse_start(k);
        wait_done(lat, bcy);
        chk({tag, "_done_latency"}, 136'(lat), 136'(10));
        chk({tag, "_busy_cycles"}, 136'(bcy), 136'(10));
        chk({tag, "_keys_valid"}, 136'(keys_valid), 136'(1));
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_stream_len"}, 136'(wr_q.size()), 136'(11));
        for (int i = 0; i < 11 && i < wr_q.size(); i++) begin
            chk($sformatf("%s_stream_%0d", tag, i), {4'h0, wr_q[i].rnd, wr_q[i].data},
                {4'h0, 4'(i), exp_rk[i]});
        end
    endtask

    task automatic readback(input string tag);
        logic [3:0]   addrs [13];
        logic [127:0] e;
        for (int i = 0; i < 11; i++) addrs[i] = 4'(10 - i);
        addrs[11] = 4'd11;
        addrs[12] = 4'd15;
        @(negedge clk);
        rd_addr = addrs[0];
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            e = (addrs[i-1] <= 4'd10) ? exp_rk[addrs[i-1]] : 128'h0;
            chk($sformatf("%s_rd_%0d", tag, addrs[i-1]), 136'(rd_data), 136'(e));
            if (i < 13) rd_addr = addrs[i];
        end
    endtask

    vec_t         vecs [2];
    logic [127:0] k1, k2, k3;
    int           lat, bcy, d0, kv_err;
    int           done_pos[$];

    initial begin
        total    = 0;
        bad      = 0;
        done_cnt = 0;
        rst      = 1'b1;
        start    = 1'b0;
        key      = '0;
        rd_addr  = '0;

        vecs[0] = '{k:    128'h2b7e151628aed2a6abf7158809cf4f3c,
                    rk1:  128'ha0fafe1788542cb123a339392a6c7605,
                    rk10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{k:    128'h0,
                    rk1:  128'h62636363626363636263636362636363,
                    rk10: 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

        init_sbox();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",        136'(busy),        136'(0));
        chk("rst_done",        136'(done),        136'(0));
        chk("rst_keys_valid",  136'(keys_valid),  136'(0));
        chk("rst_rk_wr_valid", 136'(rk_wr_valid), 136'(0));
        chk("rst_rk_wr_round", 136'(rk_wr_round), 136'(0));
        chk("rst_rk_wr_data",  136'(rk_wr_data),  136'(0));
        chk("rst_rd_data",     136'(rd_data),     136'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", 136'(busy), 136'(0));

        // Known-answer vectors
        for (int i = 0; i < 2; i++) begin
            model_expand(vecs[i].k);
            do_expand($sformatf("kat%0d", i), vecs[i].k);
            check_stream($sformatf("kat%0d", i));
            if (wr_q.size() == 11) begin
                chk($sformatf("kat%0d_rk1", i),  136'(wr_q[1].data),  136'(vecs[i].rk1));
                chk($sformatf("kat%0d_rk10", i), 136'(wr_q[10].data), 136'(vecs[i].rk10));
            end
            readback($sformatf("kat%0d", i));
            chk($sformatf("kat%0d_hold_valid", i), 136'(rk_wr_valid), 136'(0));
            chk($sformatf("kat%0d_hold_round", i), 136'(rk_wr_round), 136'(10));
            chk($sformatf("kat%0d_hold_data", i),  136'(rk_wr_data),  136'(vecs[i].rk10));
        end

        // Random keys against the reference model
        for (int i = 0; i < 4; i++) begin
            k1 = {$urandom, $urandom, $urandom, $urandom};
            model_expand(k1);
            do_expand($sformatf("rnd%0d", i), k1);
            check_stream($sformatf("rnd%0d", i));
        end
        readback("rnd_last");

        // Start while busy is ignored
        k1 = {$urandom, $urandom, $urandom, $urandom};
        k2 = ~k1;
        model_expand(k1);
        d0 = done_cnt;
        pulse_start(k1);
        repeat (3) @(posedge clk);
        pulse_start(k2);
        wait_done(lat, bcy);
        repeat (15) @(negedge clk);
        chk("busy_start_done_count", 136'(done_cnt - d0), 136'(1));
        chk("busy_start_keys_valid", 136'(keys_valid), 136'(1));
        readback("busy_start");

        // Reset in the middle of expansion
        k3 = {$urandom, $urandom, $urandom, $urandom};
        pulse_start(k3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        chk("midrst_busy",       136'(busy),       136'(0));
        chk("midrst_keys_valid", 136'(keys_valid), 136'(0));
        chk("midrst_done",       136'(done),       136'(0));
        repeat (15) @(negedge clk);
        chk("midrst_no_done",    136'(done_cnt - d0), 136'(0));
        chk("midrst_kv_stays_0", 136'(keys_valid), 136'(0));
        model_expand(k3);
        do_expand("after_rst", k3);
        check_stream("after_rst");

        // Start held high: back-to-back expansions
        k1 = {$urandom, $urandom, $urandom, $urandom};
        model_expand(k1);
        kv_err = 0;
        @(negedge clk);
        start = 1'b1;
        key   = k1;
        for (int n = 0; n < 45; n++) begin
            @(negedge clk);
            if (done) done_pos.push_back(n);
            if (keys_valid !== done) kv_err++;
        end
        start = 1'b0;
        chk("held_kv_only_with_done", 136'(kv_err), 136'(0));
        chk("held_done_count", 136'(done_pos.size()), 136'(4));
        if (done_pos.size() > 0) chk("held_first_done", 136'(done_pos[0]), 136'(10));
        for (int i = 1; i < done_pos.size(); i++) begin
            chk($sformatf("held_done_gap_%0d", i), 136'(done_pos[i] - done_pos[i-1]), 136'(11));
        end
        for (int n = 0; n < 15 && busy; n++) @(negedge clk);
        chk("held_drained", 136'(busy), 136'(0));
        chk("held_final_kv", 136'(keys_valid), 136'(1));
        readback("held");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes128_key_schedule_ctrl.md
Name: aes128_key_schedule_ctrl

Overview:
Sequences the existing combinational one-round step `keyExpansion128` to generate all AES-128 round keys, one round per clock, starting from a cipher key. Stores round keys 0..NR in an internal register file. A registered read port serves the cipher/inverse-cipher round controller in any order (forward or reverse). Sits between the key-load interface and the AES round datapath.

Parameters:
NR, 10, number of rounds; only 10 is supported (AES-128), and elaboration must fail for any other value.
RK_AW, 4, round-key read address width.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle request to expand `key`; sampled only in IDLE.
key  in  128  cipher key; word w0 at [127:96], w3 at [31:0].
busy  out  1  high while expansion is in progress.
done  out  1  one-cycle pulse when round key NR has been written.
keys_valid  out  1  high when a complete schedule is stored.
rk_wr_valid  out  1  pulse on each round-key write (stream tap).
rk_wr_round  out  4  index of the round key being written.
rk_wr_data  out  128  round key being written.
rd_addr  in  RK_AW  round-key index to read.
rd_data  out  128  registered round key at `rd_addr`.

Behaviour:
- Reset (synchronous; `rst` high at a clk edge):
  - state=IDLE, round counter=0.
  - busy=0, done=0, keys_valid=0, rk_wr_valid=0, rk_wr_round=0, rk_wr_data=0, rd_data=0.
  - Register file contents are don't-care.
  - Reset mid-expansion aborts it; no done pulse; keys_valid stays 0 until the next full expansion.
- States:
  - IDLE: start=1 -> rk[0]<=key; rk_wr_valid=1, rk_wr_round=0, rk_wr_data=key; round<=1; keys_valid<=0; busy<=1; go to EXPAND. start=0 -> stay.
  - EXPAND: instance input = rk[round-1], rCon = {RC[round],24'h0}.
    - rk[round] <= instance output; rk_wr_valid=1 with round and data.
    - round<NR -> round<=round+1.
    - round==NR -> busy<=0, done<=1 for one cycle, keys_valid<=1, go to IDLE.
- RC table: 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
- Latency: start sampled at edge E0. rk[r] is written at edge E0+r. done, keys_valid and busy=0 are visible after edge E0+10. busy is high for exactly 10 cycles.
- start while busy is ignored; key changes during EXPAND have no effect, because the key is captured at E0.
- start in the same cycle done is high: accepted, since the state is already IDLE. A new expansion begins and keys_valid drops after that edge.
- Read port:
  - rd_data <= rk[rd_addr] every cycle; 1-cycle latency.
  - rd_addr>NR -> rd_data<=0.
  - Reads during EXPAND are permitted; they return already-written keys or stale contents, and the consumer gates on keys_valid.
  - A read of index r at the same edge rk[r] is written returns the old value (no write-through).
- rk_wr_* outputs are registered and valid only when rk_wr_valid=1. Otherwise they hold their last value.
- No other outputs change in IDLE.

Decomposition:
- Shared package aes_pkg:
  - AES128_NR=10.
  - Rcon byte table (index 1..10).
  - State enum {IDLE, EXPAND}.
  - 128-bit round-key typedef.
- Sub-modules: the one instance of `keyExpansion128` for the datapath. Register file and FSM are inline; no further sub-module.

Test Plan:
1. FIPS-197 A.1 vector, key 2b7e151628aed2a6abf7158809cf4f3c, start pulse:
   - rk_wr_valid for rounds 0..10 on consecutive cycles.
   - rk[1]=a0fafe1788542cb123a339392a6c7605.
   - rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
   - done exactly 10 cycles after start sampled; keys_valid=1.
2. After test 1, read rd_addr 10 down to 0 back-to-back -> rd_data matches the FIPS schedule with 1-cycle latency; rd_addr=11 and 15 -> 0.
3. All-zero key -> rk[1]=62636363626363636263636362636363, rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
4. Second start with a different key while busy (cycle 4) -> ignored; final schedule is the first key's, only one done pulse.
5. rst asserted at EXPAND round 5 -> next cycle busy=0, keys_valid=0, no done. A new start then completes normally in 10 cycles.
6. start held high continuously -> back-to-back expansions. done every 11 cycles (10 busy + 1 IDLE), keys_valid high only in the done/IDLE cycle; start coincident with done is accepted.
